nios2vga_led_pio_arbiter: RTL

Shares the 18-bit red LED PIO register between two hardware requesters, e.g. the spectrum level-meter and the status/heartbeat logic. It grants one requester at a time under round-robin priority and issues a single Avalon-MM write to the PIO's s1 data register at address 0. It then enforces a programmable idle gap before the next grant. It sits between the requesters and the PIO slave port, in parallel with the Nios II master path.

---
 rtl/nios2vga_led_pio_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/nios2vga_led_pio_arbiter.sv
// Round-robin arbiter that shares the red LED PIO data register between two
// hardware requesters. Each grant produces one single-cycle Avalon-MM write
// to address 0, followed by MIN_GAP forced idle cycles.
//
// Handshake: reqN is a level request, sampled only while the FSM is idle.
// ackN is a one-cycle pulse that coincides exactly with the write strobe
// cycle carrying requester N's word. Data is captured on the grant edge, so
// a requester may change dataN as soon as it sees ackN.
module nios2vga_led_pio_arbiter #(
   parameter int DATA_W  = 18,
   parameter int MIN_GAP = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req0,
   input  logic [DATA_W-1:0] data0,
   output logic              ack0,
   input  logic              req1,
   input  logic [DATA_W-1:0] data1,
   output logic              ack1,
   output logic [1:0]        m_address,
   output logic              m_chipselect,
   output logic              m_write_n,
   output logic [31:0]       m_writedata,
   output logic [DATA_W-1:0] shadow,
   output logic              last_grant,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Counter only ever holds values 0 .. MIN_GAP-1.
   localparam int CNT_W      = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
   localparam int GAP_LOAD_I = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_LOAD_I);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_cs;
   logic              r_wn;
   logic [DATA_W-1:0] r_word;
   logic              r_ack0;
   logic              r_ack1;
   logic [DATA_W-1:0] r_shadow;
   logic              r_last;

   logic              w_any_req;
   logic              w_sel;

   // Pick the requester to serve: a lone request wins, a tie goes to the
   // requester that was not served last.
   always_comb begin
      w_any_req = req0 | req1;
      w_sel     = (req0 & req1) ? ~r_last : req1;
   end

   // Arbitration FSM with all bus, ack and status outputs registered.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_cs     <= 1'b0;
         r_wn     <= 1'b1;
         r_word   <= '0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_shadow <= '0;
         r_last   <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_state <= ST_WRITE;
                  r_cs    <= 1'b1;
                  r_wn    <= 1'b0;
                  r_word  <= w_sel ? data1 : data0;
                  r_last  <= w_sel;
                  r_ack0  <= ~w_sel;
                  r_ack1  <= w_sel;
               end
            end
            ST_WRITE: begin
               r_cs     <= 1'b0;
               r_wn     <= 1'b1;
               r_ack0   <= 1'b0;
               r_ack1   <= 1'b0;
               r_shadow <= r_word;
               if (MIN_GAP > 0) begin
                  r_state <= ST_GAP;
                  r_cnt   <= GAP_LOAD;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_GAP: begin
               if (r_cnt == '0) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_cs    <= 1'b0;
               r_wn    <= 1'b1;
               r_ack0  <= 1'b0;
               r_ack1  <= 1'b0;
            end
         endcase
      end
   end

   assign ack0         = r_ack0;
   assign ack1         = r_ack1;
   assign m_address    = 2'b00;
   assign m_chipselect = r_cs;
   assign m_write_n    = r_wn;
   assign m_writedata  = {{(32-DATA_W){1'b0}}, r_word};
   assign shadow       = r_shadow;
   assign last_grant   = r_last;
   assign dbg_state    = r_state;

endmodule
